alu_share_arbiter: RTL and testbench

//   Shares one combinational 32-bit ALU among NUM_REQ requesters (e.g. issue pipe, AGU, CSR unit).

---
 rtl/alu_share_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter sharing one combinational 32-bit ALU among
//               NUM_REQ requesters, one operation in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_rs1,
    input  logic [NUM_REQ*32-1:0] req_rs2,
    input  logic [NUM_REQ*4-1:0]  req_op,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_rd,
    output logic                  rsp_zero,
    output logic                  rsp_illegal,
    output logic [31:0]           alu_rs1,
    output logic [31:0]           alu_rs2,
    output logic [3:0]            alu_operation,
    input  logic [31:0]           alu_rd_value,
    input  logic                  alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [PTR_W:0] C_NUM_REQ = (PTR_W+1)'(NUM_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [31:0]        r_rs1;
    logic [31:0]        r_rs2;
    logic [3:0]         r_op;
    logic [31:0]        r_rd;
    logic               r_zero;
    logic               r_illegal;

    logic               w_grant_vld;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W:0]     w_cand;
    logic [PTR_W:0]     w_ptr_inc;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [31:0]        w_sel_rs1;
    logic [31:0]        w_sel_rs2;
    logic [3:0]         w_sel_op;
    logic               w_accept;
    logic               w_legal;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_rsp_valid;

    // Search starts at the pointer and wraps, so the last winner goes to the back.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_cand >= C_NUM_REQ) begin
                w_cand = w_cand - C_NUM_REQ;
            end
            if (!w_grant_vld && req_valid[w_cand[PTR_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_rs1 = '0;
        w_sel_rs2 = '0;
        w_sel_op  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                w_sel_rs1 = req_rs1[32*i +: 32];
                w_sel_rs2 = req_rs2[32*i +: 32];
                w_sel_op  = req_op[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_ptr_inc = {1'b0, w_grant_idx} + (PTR_W+1)'(1);
        w_ptr_nxt = (w_ptr_inc >= C_NUM_REQ) ? '0 : w_ptr_inc[PTR_W-1:0];
    end

    always_comb begin
        case (r_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1101: w_legal = 1'b1;
            default:                                       w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_rsp_valid = '0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_req_ready[w_grant_idx] = 1'b1;
                    w_accept                 = 1'b1;
                    w_state_nxt              = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid[r_owner] = 1'b1;
                if (rsp_ready[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_owner   <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_op      <= '0;
            r_rd      <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rs1   <= w_sel_rs1;
                r_rs2   <= w_sel_rs2;
                r_op    <= w_sel_op;
                r_owner <= w_grant_idx;
                r_ptr   <= w_ptr_nxt;
            end
            // Illegal opcodes never trust the ALU output.
            if (r_state == ST_EXEC) begin
                r_rd      <= w_legal ? alu_rd_value : 32'd0;
                r_zero    <= w_legal ? alu_zero : 1'b1;
                r_illegal <= ~w_legal;
            end
        end
    end

    assign req_ready     = w_req_ready;
    assign rsp_valid     = w_rsp_valid;
    assign rsp_rd        = r_rd;
    assign rsp_zero      = r_zero;
    assign rsp_illegal   = r_illegal;
    assign alu_rs1       = r_rs1;
    assign alu_rs2       = r_rs2;
    assign alu_operation = r_op;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter with an ALU model,
//               a response scoreboard, a vector table and directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int PTR_W   = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_rs1;
    logic [NUM_REQ*32-1:0] req_rs2;
    logic [NUM_REQ*4-1:0]  req_op;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [31:0]           rsp_rd;
    logic                  rsp_zero;
    logic                  rsp_illegal;
    logic [31:0]           alu_rs1;
    logic [31:0]           alu_rs2;
    logic [3:0]            alu_operation;
    logic [31:0]           alu_rd_value;
    logic                  alu_zero;

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd(rsp_rd), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_operation(alu_operation),
        .alu_rd_value(alu_rd_value), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Shared ALU model; illegal opcodes return junk that the DUT must discard.
    always_comb begin
        case (alu_operation)
            4'b0000: alu_rd_value = alu_rs1 + alu_rs2;
            4'b0001: alu_rd_value = alu_rs1 - alu_rs2;
            4'b0010: alu_rd_value = alu_rs1 ^ alu_rs2;
            4'b0011: alu_rd_value = alu_rs1 | alu_rs2;
            4'b0100: alu_rd_value = alu_rs1 & alu_rs2;
            4'b0101: alu_rd_value = alu_rs1 << alu_rs2[4:0];
            4'b0110: alu_rd_value = alu_rs1 >> alu_rs2[4:0];
            4'b0111: alu_rd_value = $signed(alu_rs1) >>> alu_rs2[4:0];
            4'b1000: alu_rd_value = ($signed(alu_rs1) < $signed(alu_rs2)) ? 32'd1 : 32'd0;
            4'b1101: alu_rd_value = (alu_rs1 < alu_rs2) ? 32'd1 : 32'd0;
            default: alu_rd_value = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_rd_value == 32'd0);
    end

    typedef struct {
        int          owner;
        logic [31:0] rd;
        logic        zero;
        logic        ill;
    } exp_t;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] rd;
        logic        z;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    exp_t exp_cur[NUM_REQ];
    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) sb.push_back(exp_cur[i]);
            end
            if (rsp_valid != '0) chk("rdy_in_resp", 32'(req_ready), 32'd0);
            if ((rsp_valid & rsp_ready) != '0) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", 32'(rsp_valid), 32'(1 << e.owner));
                    chk("rsp_rd", rsp_rd, e.rd);
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    chk("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
                end
            end
        end
    end

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] rd,
                           input logic z, input logic ill);
        req_rs1[32*idx +: 32] = a;
        req_rs2[32*idx +: 32] = b;
        req_op[4*idx +: 4]    = op;
        exp_cur[idx]          = '{idx, rd, z, ill};
    endtask

    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] rd,
                        input logic z, input logic ill);
        int n;
        set_req(idx, a, b, op, rd, z, ill);
        req_valid[idx] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[idx] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[idx]) fail_now("accept_timeout");
        else chk("ready_onehot", 32'(req_ready), 32'(1 << idx));
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid != '0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int g;
        int cnt[NUM_REQ];
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{0, 32'd5,         32'd7,         4'b0000, 32'd12,        1'b0, 1'b0};
        vecs[1]  = '{1, 32'h10,        32'h10,        4'b0001, 32'd0,         1'b1, 1'b0};
        vecs[2]  = '{0, 32'hFF00FF00,  32'h0FF00FF0,  4'b0010, 32'hF0F0F0F0,  1'b0, 1'b0};
        vecs[3]  = '{1, 32'hF0000000,  32'h0000000F,  4'b0011, 32'hF000000F,  1'b0, 1'b0};
        vecs[4]  = '{0, 32'h12345678,  32'h0000FFFF,  4'b0100, 32'h00005678,  1'b0, 1'b0};
        vecs[5]  = '{1, 32'd1,         32'd36,        4'b0101, 32'h10,        1'b0, 1'b0};
        vecs[6]  = '{0, 32'h80000000,  32'd31,        4'b0110, 32'd1,         1'b0, 1'b0};
        vecs[7]  = '{1, 32'h80000000,  32'd4,         4'b0111, 32'hF8000000,  1'b0, 1'b0};
        vecs[8]  = '{0, 32'hFFFFFFFF,  32'd0,         4'b1000, 32'd1,         1'b0, 1'b0};
        vecs[9]  = '{1, 32'hFFFFFFFF,  32'd0,         4'b1101, 32'd0,         1'b1, 1'b0};
        vecs[10] = '{0, 32'd0,         32'd1,         4'b0001, 32'hFFFFFFFF,  1'b0, 1'b0};
        vecs[11] = '{1, 32'd3,         32'd4,         4'b1010, 32'd0,         1'b1, 1'b1};
        vecs[12] = '{0, 32'd9,         32'd9,         4'b1101, 32'd0,         1'b1, 1'b0};
        vecs[13] = '{1, 32'd2,         32'd3,         4'b1111, 32'd0,         1'b1, 1'b1};
        vecs[14] = '{0, 32'd2,         32'd3,         4'b1001, 32'd0,         1'b1, 1'b1};
        vecs[15] = '{1, 32'd7,         32'd0,         4'b0000, 32'd7,         1'b0, 1'b0};

        rst_n     = 1'b1;
        req_valid = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_op    = '0;
        rsp_ready = '1;
        for (int i = 0; i < NUM_REQ; i++) exp_cur[i] = '{i, 32'd0, 1'b0, 1'b0};
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_rs1", alu_rs1, 32'd0);
        chk("rst_alu_rs2", alu_rs2, 32'd0);
        chk("rst_alu_op", 32'(alu_operation), 32'd0);
        chk("rst_rsp_rd", rsp_rd, 32'd0);
        chk("rst_rsp_flags", {30'd0, rsp_zero, rsp_illegal}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Table: each op alone, with exact latency of accept -> EXEC -> RESP.
        for (int v = 0; v < 16; v++) begin
            send(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].rd, vecs[v].z, vecs[v].ill);
            @(negedge clk);
            chk("lat_exec", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk("lat_resp", 32'(rsp_valid), 32'(1 << vecs[v].idx));
            wait_drain();
        end
        chk("alu_hold_rs1", alu_rs1, 32'd7);
        chk("alu_hold_op", 32'(alu_operation), 32'd0);

        // Both requesters always valid after reset: grants alternate from 0.
        do_reset();
        for (int r = 0; r < NUM_REQ; r++) begin
            cnt[r] = 0;
            a = 32'(100 + 10 * r);
            b = 32'(r + 1);
            set_req(r, a, b, 4'b0000, a + b, 1'b0, 1'b0);
        end
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == '0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (req_ready == '0) begin
                fail_now("rr_timeout");
                break;
            end
            g = req_ready[1] ? 1 : 0;
            chk("rr_grant", 32'(g), 32'(k % 2));
            @(posedge clk);
            #1;
            cnt[g]++;
            a = 32'(100 + 10 * g + cnt[g]);
            b = 32'(g + 1 + 2 * cnt[g]);
            set_req(g, a, b, 4'b0000, a + b, 1'b0, 1'b0);
            if (k == 3) req_valid = '0;
        end
        wait_drain();

        // Owner stalls the response; result holds and the other request waits.
        rsp_ready = '0;
        set_req(1, 32'd20, 32'd5, 4'b0001, 32'd15, 1'b0, 1'b0);
        req_valid[1] = 1'b1;
        send(0, 32'd3, 32'd4, 4'b0000, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("stall_valid0", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1 rsp_ready[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rd", rsp_rd, 32'd7);
            chk("stall_flags", {30'd0, rsp_zero, rsp_illegal}, 32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[1]) fail_now("pending_timeout");
        else chk("pending_accept", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_drain();

        // Reset in EXEC drops the op and returns the pointer to requester 0.
        send(1, 32'd1, 32'd2, 4'b0000, 32'd3, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_alu_rs1", alu_rs1, 32'd0);
        rst_n = 1'b1;
        sb.delete();
        set_req(0, 32'd40, 32'd2, 4'b0000, 32'd42, 1'b0, 1'b0);
        set_req(1, 32'd50, 32'd3, 4'b0000, 32'd53, 1'b0, 1'b0);
        req_valid = '1;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (req_ready == '0) fail_now("post_reset_timeout");
        else chk("post_reset_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!req_ready[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[1]) fail_now("post_reset_req1_timeout");
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_drain();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
